// File: rtl/dmi_jtag_dr.sv
// DMI JTAG DR stage: DTMCS and DMIACCESS shift registers plus the TCK-domain DMI request/response FSM.
// Handshake: a request transfers on a cycle where valid and ready are both high; valid stays up until then.
module dmi_jtag_dr #(
  parameter int          AbitsW     = 7,
  parameter logic [2:0]  IdleCycles = 3'd1,
  parameter logic [3:0]  Version    = 4'd1
) (
  input  logic              tck_i,
  input  logic              trst_i,
  input  logic              dmi_clear_i,
  input  logic              capture_i,
  input  logic              shift_i,
  input  logic              update_i,
  input  logic              tdi_i,
  input  logic              dtmcs_select_i,
  output logic              dtmcs_tdo_o,
  input  logic              dmi_select_i,
  output logic              dmi_tdo_o,
  output logic              dmi_req_valid_o,
  input  logic              dmi_req_ready_i,
  output logic [AbitsW-1:0] dmi_req_addr_o,
  output logic [1:0]        dmi_req_op_o,
  output logic [31:0]       dmi_req_data_o,
  input  logic              dmi_resp_valid_i,
  output logic              dmi_resp_ready_o,
  input  logic [31:0]       dmi_resp_data_i,
  input  logic [1:0]        dmi_resp_resp_i,
  output logic              dmi_hardreset_o
);

  localparam int DmiW = AbitsW + 34;
  localparam logic [5:0] AbitsField = 6'(AbitsW);

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] ErrFail = 2'd2;
  localparam logic [1:0] ErrBusy = 2'd3;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Req      = 2'd1,
    WaitResp = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       dtmcs_q;
  logic [DmiW-1:0]   dmi_q;
  logic [1:0]        error_q;
  logic [AbitsW-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        op_q;
  logic              valid_q;
  logic              resp_ready_q;
  logic              hardreset_q;

  logic [31:0]       dtmcs_capture;
  logic [1:0]        dmi_stat;
  logic [AbitsW-1:0] upd_addr;
  logic [31:0]       upd_data;
  logic [1:0]        upd_op;
  logic              dtmcs_update;
  logic              dmi_update;
  logic              flush;

  always_comb begin
    dtmcs_capture = {14'd0, 2'b00, 1'b0, IdleCycles, error_q, AbitsField, Version};
    upd_addr      = dmi_q[DmiW-1 -: AbitsW];
    upd_data      = dmi_q[33:2];
    upd_op        = dmi_q[1:0];
    dtmcs_update  = dtmcs_select_i & update_i;
    dmi_update    = dmi_select_i & update_i;
    // Test-Logic-Reset and dmihardreset share one flush path
    flush         = dmi_clear_i | (dtmcs_update & dtmcs_q[17]);
    if (error_q != 2'd0) begin
      dmi_stat = error_q;
    end else if (state_q != Idle) begin
      dmi_stat = ErrBusy;
    end else begin
      dmi_stat = 2'd0;
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      dtmcs_q <= '0;
      dmi_q   <= '0;
    end else if (!dmi_clear_i) begin
      if (dtmcs_select_i) begin
        if (capture_i) begin
          dtmcs_q <= dtmcs_capture;
        end else if (shift_i) begin
          dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
        end
      end
      if (dmi_select_i) begin
        if (capture_i) begin
          dmi_q <= {addr_q, data_q, dmi_stat};
        end else if (shift_i) begin
          dmi_q <= {tdi_i, dmi_q[DmiW-1:1]};
        end
      end
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q      <= Idle;
      error_q      <= 2'd0;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= 2'd0;
      valid_q      <= 1'b0;
      resp_ready_q <= 1'b0;
      hardreset_q  <= 1'b0;
    end else begin
      hardreset_q <= 1'b0;
      if (flush) begin
        state_q      <= Idle;
        error_q      <= 2'd0;
        addr_q       <= '0;
        data_q       <= '0;
        op_q         <= 2'd0;
        valid_q      <= 1'b0;
        resp_ready_q <= 1'b0;
        hardreset_q  <= 1'b1;
      end else begin
        if (dtmcs_update && dtmcs_q[16]) begin
          error_q <= 2'd0;
        end
        // Capturing while a transaction is outstanding latches a sticky busy error
        if (dmi_select_i && capture_i && error_q == 2'd0 && state_q != Idle) begin
          error_q <= ErrBusy;
        end
        if (dmi_update && error_q == 2'd0) begin
          if (state_q != Idle) begin
            error_q <= ErrBusy;
          end else if (upd_op == OpRead) begin
            addr_q  <= upd_addr;
            op_q    <= OpRead;
            state_q <= Req;
            valid_q <= 1'b1;
          end else if (upd_op == OpWrite) begin
            addr_q  <= upd_addr;
            data_q  <= upd_data;
            op_q    <= OpWrite;
            state_q <= Req;
            valid_q <= 1'b1;
          end
        end
        case (state_q)
          Req: begin
            if (dmi_req_ready_i) begin
              state_q      <= WaitResp;
              valid_q      <= 1'b0;
              resp_ready_q <= 1'b1;
            end
          end
          WaitResp: begin
            if (dmi_resp_valid_i) begin
              if (op_q == OpRead) begin
                data_q <= dmi_resp_data_i;
              end
              if (error_q == 2'd0 && (dmi_resp_resp_i == ErrFail || dmi_resp_resp_i == ErrBusy)) begin
                error_q <= dmi_resp_resp_i;
              end
              state_q      <= Idle;
              resp_ready_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dtmcs_tdo_o      = dtmcs_q[0];
  assign dmi_tdo_o        = dmi_q[0];
  assign dmi_req_valid_o  = valid_q;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_op_o     = op_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmi_hardreset_o  = hardreset_q;

endmodule
